seven_ones_counter: RTL and testbench
=====================================

Name: seven_ones_counter

Overview:
- Registered population counter for a 7-bit input word. Outputs the number of asserted bits (0..7) as a 3-bit binary count.
- Two independent count paths are built and compared every cycle:
  - a structural full-adder tree;
  - a dataflow (continuous-assignment sum) reference.
- Any disagreement raises a mismatch flag.
- Sits as a leaf utility in datapath/self-check logic wherever a ones-count of a small vector is needed.

Parameters:
- none (width fixed at 7 inputs, 3-bit count)

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  qualifies a; sample taken on the rising clk edge when high
- a  input  7  data word; a[0]..a[6] are equal-weight bits
- count  output  3  registered ones-count from the structural adder tree; count[0] is the LSB
- count_ref  output  3  registered ones-count from the dataflow path
- out_valid  output  1  high for exactly one cycle, the cycle after an accepted sample
- mismatch  output  1  registered; high when the two paths disagreed for the accepted sample

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- Reset: on a rising edge with rst=1:
  - count=0, count_ref=0, out_valid=0, mismatch=0;
  - rst has priority over in_valid.
- Structural path: fa0 = FA(a[0],a[1],a[2]) and fa1 = FA(a[3],a[4],a[5]) give sums s0,s1 and carries c0,c1.
  - fa2 = FA(s0,s1,a[6]) gives bit0 = sum, plus carry k.
  - fa3 = FA(c0,c1,k) gives bit1 = sum, bit2 = carry.
- Dataflow path: zero-extended sum of the 7 bits to 3 bits. Overflow is impossible (max 7).
- Latency: 1 cycle. If in_valid=1 at edge N, then at edge N, after the edge:
  - count and count_ref hold the count of a;
  - out_valid=1;
  - mismatch = (structural != dataflow).
- If in_valid=0 at an edge:
  - out_valid=0;
  - count, count_ref and mismatch hold their previous values.
- Back-to-back samples are accepted every cycle; no stall and no backpressure.
- rst asserted mid-stream: the in-flight result is discarded and outputs are 0 on the next edge.
- Boundaries: a=0 gives 0; a=7'h7F gives 7. Each single-bit input alone gives 1, regardless of position.
- In correct hardware, mismatch is never 1. It exists for fault/equivalence checking only.

Decomposition:
- Shared package: constant IN_W=7 and CNT_W=3; typedef count_t as a 3-bit logic.
- One natural sub-module: full_adder (a, b, cin -> sum, cout). Instantiate it four times in the structural path.

Test Plan:
- Reset, then in_valid=1 with a=0 -> next cycle count=0, count_ref=0, out_valid=1, mismatch=0.
- Incremental walk, one change per sample; the count after each step is listed:
  - set a[0] -> 1
  - set a[3] -> 2
  - set a[4] -> 3
  - set a[5] -> 4
  - clear a[0] -> 3
  - set a[2] -> 4
  - set a[6] -> 5
  - clear a[2] -> 4
  - clear a[3] -> 3
  - clear a[4] -> 2
  - clear a[5] -> 1
  - set a[2] -> 2
  - mismatch=0 throughout.
- Each single bit a=1<<i (i=0..6) -> count=1. Then a=7'h7F -> count=7 (3'b111); a=7'h55 -> 4.
- Hold and reset:
  - in_valid=0 for 3 cycles after a count of 5 -> count stays 5 and out_valid=0;
  - assert rst with in_valid=1, a=7'h7F -> outputs 0, out_valid=0.
- Exhaustive sweep of all 128 values, back-to-back every cycle -> count == count_ref == $countones(a) one cycle later, mismatch never set.

Source files
------------

// File: rtl/seven_ones_counter_pkg.sv
// Shared widths and types for the 7-bit ones counter.
package seven_ones_counter_pkg;
    localparam int IN_W  = 7;
    localparam int CNT_W = 3;

    typedef logic [CNT_W-1:0] count_t;
endpackage

// File: rtl/seven_ones_counter_full_adder.sv
// Single-bit full adder used as the building block of the structural count tree.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/seven_ones_counter.sv
// Registered 7-bit population counter with a structural adder tree and an
// independent dataflow reference; a mismatch flag reports any disagreement.
module seven_ones_counter
    import seven_ones_counter_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [IN_W-1:0] a,
    output count_t          count,
    output count_t          count_ref,
    output logic            out_valid,
    output logic            mismatch
);
    logic   s0, s1, c0, c1, k;
    logic   bit0, bit1, bit2;
    count_t cnt_str_p0;
    count_t cnt_ref_p0;

    count_t cnt_str_p1;
    count_t cnt_ref_p1;
    logic   vld_p1;
    logic   mismatch_p1;

    // stage p0: two independent combinational counts of a
    full_adder u_fa0 (.a(a[0]), .b(a[1]), .cin(a[2]), .sum(s0),   .cout(c0));
    full_adder u_fa1 (.a(a[3]), .b(a[4]), .cin(a[5]), .sum(s1),   .cout(c1));
    full_adder u_fa2 (.a(s0),   .b(s1),   .cin(a[6]), .sum(bit0), .cout(k));
    full_adder u_fa3 (.a(c0),   .b(c1),   .cin(k),    .sum(bit1), .cout(bit2));

    assign cnt_str_p0 = {bit2, bit1, bit0};

    assign cnt_ref_p0 = {2'b00, a[0]} + {2'b00, a[1]} + {2'b00, a[2]} + {2'b00, a[3]}
                      + {2'b00, a[4]} + {2'b00, a[5]} + {2'b00, a[6]};

    // stage p1: registered results; data only updates on accepted samples
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_str_p1  <= '0;
            cnt_ref_p1  <= '0;
            vld_p1      <= 1'b0;
            mismatch_p1 <= 1'b0;
        end else begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                cnt_str_p1  <= cnt_str_p0;
                cnt_ref_p1  <= cnt_ref_p0;
                mismatch_p1 <= (cnt_str_p0 != cnt_ref_p0);
            end
        end
    end

    assign count     = cnt_str_p1;
    assign count_ref = cnt_ref_p1;
    assign out_valid = vld_p1;
    assign mismatch  = mismatch_p1;
endmodule

// File: tb/tb_seven_ones_counter.sv
// Directed table-driven bench for seven_ones_counter plus hold/reset and exhaustive sequences.
module tb_seven_ones_counter;
    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [6:0] a;
    logic [2:0] count;
    logic [2:0] count_ref;
    logic       out_valid;
    logic       mismatch;

    int checks;
    int failures;

    typedef struct {
        logic       vin;
        logic [6:0] a;
        logic [2:0] exp_cnt;
        logic       exp_vld;
    } vec_t;

    vec_t vecs[$];

    seven_ones_counter dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .a        (a),
        .count    (count),
        .count_ref(count_ref),
        .out_valid(out_valid),
        .mismatch (mismatch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_and_sample(input logic r, input logic v, input logic [6:0] val);
        @(negedge clk);
        rst      = r;
        in_valid = v;
        a        = val;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [2:0] ec, input logic [2:0] er,
                         input logic ev, input logic em);
        checks++;
        if (count !== ec || count_ref !== er || out_valid !== ev || mismatch !== em) begin
            failures++;
            $display("FAIL %s: got count=%0d count_ref=%0d out_valid=%0b mismatch=%0b, want count=%0d count_ref=%0d out_valid=%0b mismatch=%0b",
                     name, count, count_ref, out_valid, mismatch, ec, er, ev, em);
        end
    endtask

    initial begin
        logic [6:0] one_hot;
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = '0;

        drive_and_sample(1'b1, 1'b1, 7'h7F);
        check("reset", 3'd0, 3'd0, 1'b0, 1'b0);

        vecs.push_back('{1'b1, 7'h00, 3'd0, 1'b1});
        vecs.push_back('{1'b1, 7'h01, 3'd1, 1'b1});
        vecs.push_back('{1'b1, 7'h09, 3'd2, 1'b1});
        vecs.push_back('{1'b1, 7'h19, 3'd3, 1'b1});
        vecs.push_back('{1'b1, 7'h39, 3'd4, 1'b1});
        vecs.push_back('{1'b1, 7'h38, 3'd3, 1'b1});
        vecs.push_back('{1'b1, 7'h3C, 3'd4, 1'b1});
        vecs.push_back('{1'b1, 7'h7C, 3'd5, 1'b1});
        vecs.push_back('{1'b1, 7'h78, 3'd4, 1'b1});
        vecs.push_back('{1'b1, 7'h70, 3'd3, 1'b1});
        vecs.push_back('{1'b1, 7'h60, 3'd2, 1'b1});
        vecs.push_back('{1'b1, 7'h40, 3'd1, 1'b1});
        vecs.push_back('{1'b1, 7'h44, 3'd2, 1'b1});
        for (int i = 0; i < 7; i++) begin
            one_hot = 7'd1 << i;
            vecs.push_back('{1'b1, one_hot, 3'd1, 1'b1});
        end
        vecs.push_back('{1'b1, 7'h7F, 3'd7, 1'b1});
        vecs.push_back('{1'b1, 7'h55, 3'd4, 1'b1});
        vecs.push_back('{1'b0, 7'h00, 3'd4, 1'b0});

        for (int i = 0; i < vecs.size(); i++) begin
            drive_and_sample(1'b0, vecs[i].vin, vecs[i].a);
            check($sformatf("vec%0d_a%02h", i, vecs[i].a),
                  vecs[i].exp_cnt, vecs[i].exp_cnt, vecs[i].exp_vld, 1'b0);
        end

        // Hold: a count of 5, then three idle cycles with changing data on a.
        drive_and_sample(1'b0, 1'b1, 7'h7C);
        check("load5", 3'd5, 3'd5, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive_and_sample(1'b0, 1'b0, 7'h7F);
            check($sformatf("hold%0d", i), 3'd5, 3'd5, 1'b0, 1'b0);
        end

        // Reset wins over a valid sample.
        drive_and_sample(1'b1, 1'b1, 7'h7F);
        check("rst_over_valid", 3'd0, 3'd0, 1'b0, 1'b0);
        drive_and_sample(1'b0, 1'b0, 7'h7F);
        check("idle_after_rst", 3'd0, 3'd0, 1'b0, 1'b0);

        // Exhaustive back-to-back sweep.
        for (int i = 0; i < 128; i++) begin
            logic [6:0] v;
            logic [2:0] e;
            v = 7'(i);
            e = 3'($countones(v));
            drive_and_sample(1'b0, 1'b1, v);
            check($sformatf("sweep_%02h", v), e, e, 1'b1, 1'b0);
        end

        drive_and_sample(1'b0, 1'b0, 7'h00);
        check("sweep_end", 3'd7, 3'd7, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
